// File: rtl/nx1_cgrom_arb.sv
// nx1_cgrom_arb: round-robin arbiter sharing one synchronous
// CG ROM read port between CH requesters with req/ack handshake.
module nx1_cgrom_arb #(
  parameter int CH  = 2,
  parameter int AW  = 11,
  parameter int DW  = 8,
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CH-1:0]    req,
  input  logic [CH*AW-1:0] addr,
  output logic [CH-1:0]    ack,
  output logic [CH*DW-1:0] data,
  output logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    mem_data
);

  localparam int TW = (CH > 1) ? $clog2(CH) : 1;

  logic [TW-1:0] ptr;
  logic [TW-1:0] gidx;
  logic          gv;
  logic [CH-1:0] busy;
  logic [CH-1:0] elig;
  logic [LAT:0]  pv;
  logic [TW-1:0] pt [LAT+1];

  // a channel competes only when idle and not in its ack cycle
  always_comb elig = req & ~busy & ~ack;

  // first eligible channel upward from ptr+1, wrapping
  always_comb begin
    int idx;
    gv   = 1'b0;
    gidx = '0;
    idx  = 0;
    for (int i = 1; i <= CH; i++) begin
      idx = (int'(ptr) + i) % CH;
      if (!gv && elig[idx]) begin
        gv   = 1'b1;
        gidx = TW'(idx);
      end
    end
  end

  // tag pipeline aligned with the ROM read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      pv <= '0;
      for (int k = 0; k <= LAT; k++)
        pt[k] <= '0;
    end else begin
      pv[0] <= gv;
      pt[0] <= gidx;
      for (int k = 1; k <= LAT; k++) begin
        pv[k] <= pv[k-1];
        pt[k] <= pt[k-1];
      end
    end
  end

  // grant issue, data capture and ack pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      ack      <= '0;
      data     <= '0;
      mem_addr <= '0;
      ptr      <= TW'(CH-1);
      busy     <= '0;
    end else begin
      ack <= '0;
      if (pv[LAT]) begin
        ack[pt[LAT]]              <= 1'b1;
        data[pt[LAT]*DW +: DW]    <= mem_data;
        busy[pt[LAT]]             <= 1'b0;
      end
      if (gv) begin
        mem_addr   <= addr[gidx*AW +: AW];
        ptr        <= gidx;
        busy[gidx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nx1_cgrom_arb.sv
// tb_nx1_cgrom_arb: vector table, directed corner sequences and
// randomized traffic against a transaction-scheduling model.
module tb_nx1_cgrom_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1;
  logic [1:0]  req0, ack0;
  logic [21:0] addr0;
  logic [15:0] data0;
  logic [10:0] ma0, ma1;
  logic [7:0]  md0, md1;
  logic [3:0]  req1, ack1;
  logic [43:0] addr1;
  logic [31:0] data1;

  logic [7:0] rom [2048];
  logic [7:0] mp1 [3];

  int n_assert = 0;
  int n_fail   = 0;

  nx1_cgrom_arb #(.CH(2), .AW(11), .DW(8), .LAT(1)) u0 (
    .clk(clk), .reset(rst0), .req(req0), .addr(addr0),
    .ack(ack0), .data(data0), .mem_addr(ma0), .mem_data(md0)
  );

  nx1_cgrom_arb #(.CH(4), .AW(11), .DW(8), .LAT(3)) u1 (
    .clk(clk), .reset(rst1), .req(req1), .addr(addr1),
    .ack(ack1), .data(data1), .mem_addr(ma1), .mem_data(md1)
  );

  // ROMs: data valid LAT clocks after the address edge
  always @(posedge clk) md0 <= rom[ma0];
  always @(posedge clk) begin
    mp1[0] <= rom[ma1];
    mp1[1] <= mp1[0];
    mp1[2] <= mp1[1];
  end
  assign md1 = mp1[2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [10:0] a0, a1;
    logic [1:0]  ack;
    logic [7:0]  d0, d1;
    logic [10:0] ma;
  } vec_t;

  function automatic vec_t mk(logic r, logic [1:0] rq,
    logic [10:0] a0, logic [10:0] a1, logic [1:0] ak,
    logic [7:0] d0, logic [7:0] d1, logic [10:0] ma);
    vec_t v;
    v.rst = r; v.req = rq; v.a0 = a0; v.a1 = a1;
    v.ack = ak; v.d0 = d0; v.d1 = d1; v.ma = ma;
    return v;
  endfunction

  vec_t tbl [22];

  // model state for randomized phase (dut index, channel)
  int          nch [2];
  int          lat [2];
  logic        pend [2][4];
  int          due  [2][4];
  logic [7:0]  pd   [2][4];
  logic [7:0]  dm   [2][4];
  logic        eack [2][4];
  int          ptrm [2];
  logic [10:0] mam  [2];

  function automatic logic get_ack(int d, int c);
    return (d == 0) ? ack0[c] : ack1[c];
  endfunction

  function automatic logic [7:0] get_data(int d, int c);
    return (d == 0) ? data0[c*8 +: 8] : data1[c*8 +: 8];
  endfunction

  function automatic logic get_req(int d, int c);
    return (d == 0) ? req0[c] : req1[c];
  endfunction

  function automatic logic [10:0] get_addr(int d, int c);
    return (d == 0) ? addr0[c*11 +: 11] : addr1[c*11 +: 11];
  endfunction

  initial begin
    int cnt0, cnt1, seen, got, lseen;
    int acnt [4];
    int aat  [4];

    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    rom[11'h123] = 8'h5A;
    rom[11'h010] = 8'h11;
    rom[11'h020] = 8'h22;
    rom[11'h7FF] = 8'hC3;
    for (int i = 0; i < 4; i++) rom[i] = 8'(i);

    rst0 = 1'b1; req0 = 2'b11; addr0 = {11'h020, 11'h010};
    rst1 = 1'b1; req1 = 4'h0;  addr1 = '0;

    // reset/idle, single read, early drop, contention start
    tbl[0]  = mk(1, 2'b11, 11'h010, 11'h020, 2'b00, 8'h00, 8'h00, 11'h000);
    tbl[1]  = mk(1, 2'b11, 11'h010, 11'h020, 2'b00, 8'h00, 8'h00, 11'h000);
    tbl[2]  = mk(1, 2'b11, 11'h010, 11'h020, 2'b00, 8'h00, 8'h00, 11'h000);
    tbl[3]  = mk(0, 2'b01, 11'h123, 11'h020, 2'b00, 8'h00, 8'h00, 11'h000);
    tbl[4]  = mk(0, 2'b01, 11'h123, 11'h020, 2'b00, 8'h00, 8'h00, 11'h123);
    tbl[5]  = mk(0, 2'b01, 11'h123, 11'h020, 2'b00, 8'h00, 8'h00, 11'h123);
    tbl[6]  = mk(0, 2'b00, 11'h123, 11'h020, 2'b01, 8'h5A, 8'h00, 11'h123);
    tbl[7]  = mk(0, 2'b10, 11'h123, 11'h7FF, 2'b00, 8'h5A, 8'h00, 11'h123);
    tbl[8]  = mk(0, 2'b00, 11'h123, 11'h7FF, 2'b00, 8'h5A, 8'h00, 11'h7FF);
    tbl[9]  = mk(0, 2'b00, 11'h123, 11'h7FF, 2'b00, 8'h5A, 8'h00, 11'h7FF);
    tbl[10] = mk(0, 2'b00, 11'h123, 11'h7FF, 2'b10, 8'h5A, 8'hC3, 11'h7FF);
    tbl[11] = mk(0, 2'b00, 11'h123, 11'h7FF, 2'b00, 8'h5A, 8'hC3, 11'h7FF);
    tbl[12] = mk(0, 2'b11, 11'h010, 11'h020, 2'b00, 8'h5A, 8'hC3, 11'h7FF);
    tbl[13] = mk(0, 2'b11, 11'h010, 11'h020, 2'b00, 8'h5A, 8'hC3, 11'h010);
    tbl[14] = mk(0, 2'b11, 11'h010, 11'h020, 2'b00, 8'h5A, 8'hC3, 11'h020);
    tbl[15] = mk(0, 2'b11, 11'h010, 11'h020, 2'b01, 8'h11, 8'hC3, 11'h020);
    tbl[16] = mk(0, 2'b11, 11'h010, 11'h020, 2'b10, 8'h11, 8'h22, 11'h020);
    tbl[17] = mk(0, 2'b11, 11'h010, 11'h020, 2'b00, 8'h11, 8'h22, 11'h010);
    tbl[18] = mk(0, 2'b11, 11'h010, 11'h020, 2'b00, 8'h11, 8'h22, 11'h020);
    tbl[19] = mk(0, 2'b00, 11'h010, 11'h020, 2'b01, 8'h11, 8'h22, 11'h020);
    tbl[20] = mk(0, 2'b00, 11'h010, 11'h020, 2'b10, 8'h11, 8'h22, 11'h020);
    tbl[21] = mk(0, 2'b00, 11'h010, 11'h020, 2'b00, 8'h11, 8'h22, 11'h020);

    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ack", i), 32'(ack0), 32'(tbl[i].ack));
      chk($sformatf("vec%0d_d0", i), 32'(data0[7:0]), 32'(tbl[i].d0));
      chk($sformatf("vec%0d_d1", i), 32'(data0[15:8]), 32'(tbl[i].d1));
      chk($sformatf("vec%0d_ma", i), 32'(ma0), 32'(tbl[i].ma));
      rst0  = tbl[i].rst;
      req0  = tbl[i].req;
      addr0 = {tbl[i].a1, tbl[i].a0};
    end

    // sustained contention: both channels served fairly
    @(posedge clk); #1;
    req0 = 2'b11; addr0 = {11'h020, 11'h010};
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (ack0[0]) begin
        cnt0++;
        chk("cont_d0", 32'(data0[7:0]), 32'h11);
      end
      if (ack0[1]) begin
        cnt1++;
        chk("cont_d1", 32'(data0[15:8]), 32'h22);
      end
    end
    chk("cont_cnt0_ok", 32'(cnt0 >= 24), 32'd1);
    chk("cont_cnt1_ok", 32'(cnt1 >= 24), 32'd1);

    // drain, then reset while a read is in flight
    req0 = 2'b00;
    repeat (6) @(posedge clk);
    #1;
    req0 = 2'b01; addr0[10:0] = 11'h123;
    @(posedge clk); #1;
    rst0 = 1'b1; req0 = 2'b00;
    @(posedge clk); #1;
    rst0 = 1'b0;
    chk("midrst_data", 32'(data0), 32'd0);
    chk("midrst_ma", 32'(ma0), 32'd0);
    seen = (ack0 != 0) ? 1 : 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack0 != 0) seen++;
    end
    chk("midrst_noack", 32'(seen), 32'd0);
    req0 = 2'b01; addr0[10:0] = 11'h010;
    got = 0; lseen = -1;
    for (int k = 1; k <= 10 && got == 0; k++) begin
      @(posedge clk); #1;
      if (ack0[0]) begin
        got = 1; lseen = k;
      end
    end
    req0 = 2'b00;
    chk("postrst_lat", 32'(lseen), 32'd3);
    chk("postrst_d0", 32'(data0[7:0]), 32'h11);

    // latency sweep on the 4-channel, LAT=3 instance
    rst1 = 1'b0; req1 = 4'hF;
    addr1 = {11'd3, 11'd2, 11'd1, 11'd0};
    for (int c = 0; c < 4; c++) begin
      acnt[c] = 0; aat[c] = -1;
    end
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++)
        if (ack1[c]) begin
          acnt[c]++; aat[c] = k; req1[c] = 1'b0;
          chk($sformatf("sweep_d%0d", c),
              32'(data1[c*8 +: 8]), 32'(c));
        end
    end
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("sweep_at%0d", c), 32'(aat[c]), 32'(c + 5));
      chk($sformatf("sweep_n%0d", c), 32'(acnt[c]), 32'd1);
    end

    // randomized traffic on both instances
    nch[0] = 2; lat[0] = 1;
    nch[1] = 4; lat[1] = 3;
    rst0 = 1'b1; rst1 = 1'b1; req0 = '0; req1 = '0;
    for (int d = 0; d < 2; d++) begin
      ptrm[d] = nch[d] - 1; mam[d] = '0;
      for (int c = 0; c < 4; c++) begin
        pend[d][c] = 1'b0; due[d][c] = 0;
        pd[d][c] = '0; dm[d][c] = '0; eack[d][c] = 1'b0;
      end
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst0 = 1'b0; rst1 = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < nch[d]; c++) begin
          eack[d][c] = pend[d][c] && (due[d][c] == t);
          if (eack[d][c]) begin
            dm[d][c] = pd[d][c]; pend[d][c] = 1'b0;
          end
          chk($sformatf("rnd_d%0d_ack%0d_t%0d", d, c, t),
              32'(get_ack(d, c)), 32'(eack[d][c]));
          chk($sformatf("rnd_d%0d_data%0d_t%0d", d, c, t),
              32'(get_data(d, c)), 32'(dm[d][c]));
        end
      end
      chk($sformatf("rnd_ma0_t%0d", t), 32'(ma0), 32'(mam[0]));
      chk($sformatf("rnd_ma1_t%0d", t), 32'(ma1), 32'(mam[1]));
      for (int c = 0; c < 2; c++) begin
        req0[c] = ($urandom_range(0, 2) != 0);
        if (!req0[c]) addr0[c*11 +: 11] = 11'($urandom);
      end
      for (int c = 0; c < 4; c++) begin
        req1[c] = ($urandom_range(0, 2) != 0);
        if (!req1[c]) addr1[c*11 +: 11] = 11'($urandom);
      end
      for (int d = 0; d < 2; d++) begin
        int g;
        g = -1;
        for (int i = 1; i <= nch[d] && g < 0; i++) begin
          int ix;
          ix = (ptrm[d] + i) % nch[d];
          if (get_req(d, ix) && !pend[d][ix] && !eack[d][ix])
            g = ix;
        end
        if (g >= 0) begin
          pend[d][g] = 1'b1;
          due[d][g]  = t + lat[d] + 2;
          pd[d][g]   = rom[get_addr(d, g)];
          mam[d]     = get_addr(d, g);
          ptrm[d]    = g;
        end
      end
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
